// File: rtl/memory_arbiter.sv
// Two-port arbiter (fetch I, load/store D) in front of a fixed-latency single-ported memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is D priority with an I starvation override.
package memory_arbiter_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic [31:0] data;
  } memory_io_req;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '{valid: 1'b0, addr: 32'h0, do_read: 4'h0,
                                                do_write: 4'h0, data: 32'h0};
  localparam memory_io_rsp memory_io_no_rsp = '{valid: 1'b0, data: 32'h0};
endpackage

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DROP_CYCLES  = MEM_LATENCY
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req i_req,
  output logic         i_ready,
  output memory_io_rsp i_rsp,
  input  memory_io_req d_req,
  output logic         d_ready,
  output memory_io_rsp d_rsp,
  output memory_io_req mem_req,
  input  memory_io_rsp mem_rsp,
  output logic         err_orphan
);

  localparam int DROP_W = (DROP_CYCLES > 0) ? $clog2(DROP_CYCLES + 1) : 1;

  logic [MEM_LATENCY-1:0] r_tag_v;
  logic [MEM_LATENCY-1:0] r_tag_own;   // 0 = I, 1 = D
  logic [3:0]             r_starve_cnt;
  logic [DROP_W-1:0]      r_drop_cnt;
  logic                   r_err_orphan;
`ifdef MEM_ARB_RR_EN
  logic                   r_rr_last;   // 0 = I, 1 = D
`endif

  logic w_i_act, w_d_act, w_grant_i, w_grant_d, w_issue;
  logic w_tail_v, w_tail_own, w_orphan;

  // Zero-mask requests still arbitrate so they reach memory and occupy a tag.
  assign w_i_act = i_req.valid;
  assign w_d_act = d_req.valid;

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!reset) begin
      if (w_i_act && w_d_act) begin
`ifdef MEM_ARB_RR_EN
        w_grant_i = r_rr_last;
        w_grant_d = !r_rr_last;
`else
        w_grant_i = (r_starve_cnt == 4'(STARVE_LIMIT));
        w_grant_d = !w_grant_i;
`endif
      end else begin
        w_grant_i = w_i_act;
        w_grant_d = w_d_act;
      end
    end
  end

  assign w_issue = w_grant_i || w_grant_d;
  assign i_ready = w_grant_i;
  assign d_ready = w_grant_d;
  assign mem_req = w_grant_i ? i_req : (w_grant_d ? d_req : memory_io_no_req);

  // Responses landing during reset belong to pre-reset requests and are never routed.
  assign w_tail_v   = r_tag_v[MEM_LATENCY-1] && !reset;
  assign w_tail_own = r_tag_own[MEM_LATENCY-1];
  assign i_rsp      = (w_tail_v && !w_tail_own) ? mem_rsp : memory_io_no_rsp;
  assign d_rsp      = (w_tail_v &&  w_tail_own) ? mem_rsp : memory_io_no_rsp;

  assign w_orphan   = mem_rsp.valid && !r_tag_v[MEM_LATENCY-1] && (r_drop_cnt == '0);
  assign err_orphan = r_err_orphan;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v      <= '0;
      r_tag_own    <= '0;
      r_starve_cnt <= '0;
      r_drop_cnt   <= DROP_W'(DROP_CYCLES);
      r_err_orphan <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_rr_last    <= 1'b0;
`endif
    end else begin
      r_tag_v[0]   <= w_issue;
      r_tag_own[0] <= w_grant_d;
      for (int k = 1; k < MEM_LATENCY; k++) begin
        r_tag_v[k]   <= r_tag_v[k-1];
        r_tag_own[k] <= r_tag_own[k-1];
      end
      if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - DROP_W'(1);
      if (w_orphan) r_err_orphan <= 1'b1;
`ifdef MEM_ARB_RR_EN
      r_starve_cnt <= '0;
      if (w_issue) r_rr_last <= w_grant_d;
`else
      if (w_i_act && !w_grant_i) r_starve_cnt <= r_starve_cnt + 4'd1;
      else                       r_starve_cnt <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: driver feeds per-port request queues, a monitor
// predicts grants and responses from a reference memory and compares every cycle.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int LAT  = 2;
  localparam int SLIM = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  memory_io_req i_req = memory_io_no_req;
  memory_io_req d_req = memory_io_no_req;
  memory_io_req mem_req;
  memory_io_rsp i_rsp, d_rsp, mem_rsp;
  logic         i_ready, d_ready, err_orphan;

  memory_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_ready(i_ready), .i_rsp(i_rsp),
    .d_req(d_req), .d_ready(d_ready), .d_rsp(d_rsp),
    .mem_req(mem_req), .mem_rsp(mem_rsp), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] data;
    int          gap;
  } stim_t;

  typedef struct {
    int          due;
    bit          is_wr;
    logic [31:0] data;
  } exp_t;

  stim_t       stq[2][$];
  exp_t        sbq[2][$];
  logic [31:0] mem[256];
  logic [31:0] rmem[256];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_grants = 0;
  bit          force_rsp = 1'b0;

  int m_wait = 0;
  bit m_last_d = 1'b0;
  bit m_err = 1'b0;
  int m_since = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: no reset, fixed latency, byte-lane masks.
  memory_io_req req_s = memory_io_no_req;
  memory_io_rsp pipe0 = memory_io_no_rsp;
  memory_io_rsp pipe1 = memory_io_no_rsp;
  localparam memory_io_rsp FORCED = '{valid: 1'b1, data: 32'hBAD0BAD0};

  always @(negedge clk) req_s = mem_req;

  always @(posedge clk) begin : memory_model
    memory_io_rsp r;
    logic [7:0]   idx;
    r = memory_io_no_rsp;
    if (req_s.valid) begin
      idx = req_s.addr[9:2];
      r.valid = (|req_s.do_read) || (|req_s.do_write);
      for (int b = 0; b < 4; b++) begin
        if (req_s.do_read[b])  r.data[8*b +: 8] = mem[idx][8*b +: 8];
        if (req_s.do_write[b]) mem[idx][8*b +: 8] <= req_s.data[8*b +: 8];
      end
    end
    pipe0 <= r;
    pipe1 <= pipe0;
  end

  assign mem_rsp = force_rsp ? FORCED : pipe1;

  function automatic memory_io_req mk(input stim_t s);
    memory_io_req q;
    q.valid = 1'b1;
    q.addr = s.addr;
    q.do_read = s.rd;
    q.do_write = s.wr;
    q.data = s.data;
    return q;
  endfunction

  // Driver: hold each request until its ready is seen, then move to the next.
  initial begin : driver
    bit acc[2];
    bit pres[2];
    pres[0] = 1'b0;
    pres[1] = 1'b0;
    forever begin
      @(negedge clk);
      acc[0] = i_ready;
      acc[1] = d_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (pres[p] && acc[p]) begin
          pres[p] = 1'b0;
          void'(stq[p].pop_front());
        end
        if (!pres[p] && stq[p].size() > 0) begin
          if (stq[p][0].gap > 0) stq[p][0].gap = stq[p][0].gap - 1;
          else pres[p] = 1'b1;
        end
      end
      i_req = pres[0] ? mk(stq[0][0]) : memory_io_no_req;
      d_req = pres[1] ? mk(stq[1][0]) : memory_io_no_req;
    end
  end

  // Monitor and reference model.
  always @(negedge clk) begin : monitor
    bit           gi, gd, any_due, orphan;
    memory_io_rsp rsp[2];
    memory_io_req rq;
    exp_t         e;
    logic [7:0]   idx;
    rsp[0] = i_rsp;
    rsp[1] = d_rsp;
    gi = 1'b0;
    gd = 1'b0;
    if (!reset) begin
      if (i_req.valid && d_req.valid) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_d) gi = 1'b1; else gd = 1'b1;
`else
        if (m_wait == SLIM) gi = 1'b1; else gd = 1'b1;
`endif
      end else begin
        gi = i_req.valid;
        gd = d_req.valid;
      end
    end
    n_cmp++;
    if (!(i_ready === gi && d_ready === gd && mem_req.valid === (gi | gd) &&
          (!gi || mem_req === i_req) && (!gd || mem_req === d_req))) begin
      n_bad++;
      $display("FAIL grant cyc=%0d got i_ready=%b d_ready=%b mem_req.valid=%b, required i=%b d=%b",
               cyc, i_ready, d_ready, mem_req.valid, gi, gd);
    end

    any_due = 1'b0;
    for (int p = 0; p < 2; p++)
      if (sbq[p].size() > 0 && sbq[p][0].due == cyc) any_due = 1'b1;

    if (reset) begin
      n_cmp++;
      if (i_rsp.valid !== 1'b0 || d_rsp.valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rsp_in_reset cyc=%0d got i_rsp.valid=%b d_rsp.valid=%b, required 0",
                 cyc, i_rsp.valid, d_rsp.valid);
      end
      sbq[0].delete();
      sbq[1].delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        while (sbq[p].size() > 0 && sbq[p][0].due < cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_missing port=%0d cyc=%0d got none, required response due at %0d",
                   p, cyc, sbq[p][0].due);
          void'(sbq[p].pop_front());
        end
        if (rsp[p].valid === 1'b1) begin
          n_cmp++;
          if (sbq[p].size() == 0 || sbq[p][0].due != cyc) begin
            n_bad++;
            $display("FAIL rsp_unexpected port=%0d cyc=%0d got data=%h, required no response",
                     p, cyc, rsp[p].data);
          end else begin
            e = sbq[p].pop_front();
            if (!e.is_wr && rsp[p].data !== e.data) begin
              n_bad++;
              $display("FAIL rsp_data port=%0d cyc=%0d got %h, required %h",
                       p, cyc, rsp[p].data, e.data);
            end
          end
        end
      end
    end

    n_cmp++;
    if (err_orphan !== m_err) begin
      n_bad++;
      $display("FAIL err_orphan cyc=%0d got %b, required %b", cyc, err_orphan, m_err);
    end
    orphan = !reset && (mem_rsp.valid === 1'b1) && !any_due && (m_since >= LAT);

    if (gi || gd) begin
      rq = gd ? d_req : i_req;
      e.due = cyc + LAT;
      e.is_wr = |rq.do_write;
      e.data = 32'h0;
      idx = rq.addr[9:2];
      for (int b = 0; b < 4; b++) begin
        if (rq.do_read[b])  e.data[8*b +: 8] = rmem[idx][8*b +: 8];
        if (rq.do_write[b]) rmem[idx][8*b +: 8] = rq.data[8*b +: 8];
      end
      sbq[gd ? 1 : 0].push_back(e);
      n_grants++;
    end

    if (reset) begin
      m_wait = 0;
      m_last_d = 1'b0;
      m_err = 1'b0;
      m_since = 0;
    end else begin
      m_wait = (i_req.valid && !gi) ? m_wait + 1 : 0;
      if (gi || gd) m_last_d = gd;
      m_err = m_err | orphan;
      if (m_since < LAT) m_since++;
    end
  end

  task automatic push(input int p, input logic [31:0] addr, input logic [3:0] rd,
                      input logic [3:0] wr, input logic [31:0] data, input int gap);
    stim_t s;
    s.addr = addr;
    s.rd = rd;
    s.wr = wr;
    s.data = data;
    s.gap = gap;
    stq[p].push_back(s);
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk);
      done = (stq[0].size() == 0 && stq[1].size() == 0 &&
              sbq[0].size() == 0 && sbq[1].size() == 0);
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_%s got pending stim=%0d/%0d exp=%0d/%0d, required all empty",
               name, stq[0].size(), stq[1].size(), sbq[0].size(), sbq[1].size());
    end
  endtask

  initial begin : main
    int g0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      rmem[i] = mem[i];
    end
    mem[4] = 32'hDEADBEEF;
    rmem[4] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    push(0, 32'h10, 4'hF, 4'h0, 32'h0, 0);
    drain("single", 50);

    for (int k = 0; k < 12; k++) begin
      push(1, 32'h100 + 32'(4 * k), 4'hF, 4'h0, 32'h0, 0);
      push(0, 32'h000 + 32'(4 * k), 4'hF, 4'h0, 32'h0, 0);
    end
    drain("contention", 100);

    push(1, 32'h40, 4'h0, 4'b0011, 32'h12345678, 0);
    push(0, 32'h40, 4'hF, 4'h0, 32'h0, 1);
    drain("store_load", 50);

    for (int k = 0; k < 150; k++) begin
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 2) == 0)
          push(p, {22'h0, 8'($urandom_range(0, 255)), 2'b00}, 4'h0,
               4'($urandom_range(1, 15)), $urandom, $urandom_range(0, 2));
        else
          push(p, {22'h0, 8'($urandom_range(0, 255)), 2'b00},
               4'($urandom_range(1, 15)), 4'h0, 32'h0, $urandom_range(0, 2));
      end
    end
    drain("random", 4000);

    g0 = n_grants;
    push(1, 32'h80, 4'hF, 4'h0, 32'h0, 0);
    push(0, 32'h84, 4'hF, 4'h0, 32'h0, 0);
    for (int k = 0; k < 20 && n_grants < g0 + 2; k++) @(posedge clk);
    n_cmp++;
    if (n_grants < g0 + 2) begin
      n_bad++;
      $display("FAIL reset_setup got %0d grants, required 2", n_grants - g0);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(posedge clk);
    drain("after_reset", 20);

    repeat (4) @(posedge clk);
    #1 force_rsp = 1'b1;
    @(posedge clk);
    #1 force_rsp = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_orphan !== 1'b1) begin
      n_bad++;
      $display("FAIL orphan_sticky got %b, required 1", err_orphan);
    end

    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_orphan !== 1'b0) begin
      n_bad++;
      $display("FAIL orphan_cleared got %b, required 0", err_orphan);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
